// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the TX FIFO and serialises them LSB-first
// as 8N1 UART frames on tx. Define UART_TX_PARITY_EN to insert an even
// parity bit between the data bits and the stop bit (8E1).
// All outputs are registered so tx never glitches.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifoData,
    input  logic       fifoEmpty,
    output logic       fifoRe,
    output logic       tx,
    output logic       busy,
    output logic       txDone
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

    // Last count of a bit period, and the count one before it (where the
    // registered txDone must be set so it is high on the final STOP cycle).
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_AT = CNT_W'(CLKS_PER_BIT - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    // Frame sequencer: every output is updated on the same edge as the
    // state it belongs to, so tx/fifoRe/busy/txDone line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            fifoRe  <= 1'b0;
            busy    <= 1'b0;
            txDone  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            fifoRe <= 1'b0;
            txDone <= 1'b0;
            case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (enable && !fifoEmpty) begin
                        state  <= LOAD;
                        fifoRe <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                // Pop happens at the end of this cycle; capture the head byte.
                LOAD: begin
                    shift   <= fifoData;
`ifdef UART_TX_PARITY_EN
                    par     <= ^fifoData;
`endif
                    state   <= START;
                    tx      <= 1'b0;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // tx already holds shift[0]; the next bit to drive is shift[1].
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                // End of stop: chain straight into LOAD when more data waits.
                STOP: begin
                    tx <= 1'b1;
                    if (cnt == DONE_AT) txDone <= 1'b1;
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (enable && !fifoEmpty) begin
                            state  <= LOAD;
                            fifoRe <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4 and a small FIFO model.
`timescale 1ns/1ps
module tb_uart_tx_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] fifoData;
    logic       fifoEmpty;
    logic       fifoRe, tx, busy, txDone;

    int tests = 0;
    int fails = 0;

    // FIFO model: bench pushes at wr, DUT pops at rd via fifoRe.
    logic [7:0] mem [0:31];
    int rd = 0;
    int wr = 0;
    assign fifoEmpty = (rd == wr);
    assign fifoData  = mem[rd[4:0]];

    always #5 clk = ~clk;

    always @(posedge clk) if (fifoRe) rd <= rd + 1;

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifoData(fifoData),
        .fifoEmpty(fifoEmpty), .fifoRe(fifoRe), .tx(tx), .busy(busy), .txDone(txDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr[4:0]] = b;
        wr++;
    endtask

    // Wait (bounded) for the LOAD cycle; returns at its negedge.
    task automatic wait_load(input string tag);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (fifoRe) seen = 1;
        end
        chk({tag, " load seen"}, 32'(seen), 32'd1);
        chk({tag, " load busy/tx"}, {30'd0, busy, tx}, 32'b11);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == NB - 1) return 1'b1;
        return ^b;
    endfunction

    // Called at the LOAD negedge; checks every cycle of the frame.
    // drop_bit/abort_bit: frame bit index at which enable drops / reset rises.
    task automatic run_frame(input logic [7:0] b, input int drop_bit, input int abort_bit);
        logic [7:0] dec = 8'h00;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk($sformatf("frame %02h bit%0d c%0d {tx,done,re,busy}", b, i, c),
                    {28'd0, tx, txDone, fifoRe, busy},
                    {28'd0, exp_bit(b, i), (i == NB - 1 && c == CPB - 1), 1'b0, 1'b1});
                if (i >= 1 && i <= 8 && c == 2) dec[i-1] = tx;
                if (i == drop_bit && c == 1) enable = 1'b0;
                if (i == abort_bit && c == 1) begin
                    reset = 1'b1;
                    return;
                end
            end
        end
        chk($sformatf("frame %02h decoded", b), {24'd0, dec}, {24'd0, b});
    endtask

    initial begin
        int p0;
        // Reset and idle with empty FIFO
        repeat (3) @(negedge clk);
        chk("reset outs", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        reset = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("idle empty", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        end

        // Single byte 0x55
        push(8'h55);
        wait_load("0x55");
        run_frame(8'h55, -1, -1);
        @(negedge clk);
        chk("after 0x55 idle", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        chk("pops after 0x55", 32'(rd), 32'd1);

        // Three back-to-back bytes: LOAD must follow STOP immediately (period 41)
        p0 = rd;
        push(8'h00); push(8'hFF); push(8'hA3);
        wait_load("b2b");
        run_frame(8'h00, -1, -1);
        @(negedge clk);
        chk("b2b load2", {31'd0, fifoRe}, 32'd1);
        run_frame(8'hFF, -1, -1);
        @(negedge clk);
        chk("b2b load3", {31'd0, fifoRe}, 32'd1);
        run_frame(8'hA3, -1, -1);
        @(negedge clk);
        chk("b2b idle", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        chk("b2b pops", 32'(rd - p0), 32'd3);

        // enable drops during data bit 3 (frame bit 4); frame must still finish
        p0 = rd;
        push(8'h3C); push(8'h11);
        wait_load("0x3C");
        run_frame(8'h3C, 4, -1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("disabled hold", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        end
        chk("disabled pops", 32'(rd - p0), 32'd1);
        enable = 1'b1;
        wait_load("0x11");
        run_frame(8'h11, -1, -1);

        // reset during data bit 5 (frame bit 6) of 0x81
        p0 = rd;
        push(8'h81); push(8'h5A);
        wait_load("0x81");
        run_frame(8'h81, -1, 6);
        @(negedge clk);
        chk("abort outs", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);
        chk("abort pops", 32'(rd - p0), 32'd1);
        reset = 1'b0;
        wait_load("0x5A");
        run_frame(8'h5A, -1, -1);
        @(negedge clk);
        chk("after 0x5A idle", {28'd0, tx, txDone, fifoRe, busy}, 32'b1000);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0, back-to-back period 45
        push(8'h07); push(8'h03);
        wait_load("par07");
        run_frame(8'h07, -1, -1);
        @(negedge clk);
        chk("par load2", {31'd0, fifoRe}, 32'd1);
        run_frame(8'h03, -1, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
